// File: rtl/mdl_timer25k_seq.sv
// mdl_timer25k_seq: sequencer for the serial 12-bit timeout counter.
// Drives count-enable / output-latch load, arbitrates snapshot requests,
// and turns TIMEOVER into timeout events with bounded automatic retry.
// All state advances only on the 2 MHz clock enable; a registered output
// "pulses in slot s" when it is set by the slot-s PCEN and held one PCEN.
module mdl_timer25k_seq #(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned RETRY_W   = 2
) (
  input  logic               i_MCLK,
  input  logic               i_RST_n,
  input  logic               i_CLK2M_PCEN_n,
  input  logic [19:0]        i_ROT20_n,
  input  logic               i_START,
  input  logic               i_STOP,
  input  logic               i_SNAP_REQ_HOST,
  input  logic               i_SNAP_REQ_FSM,
  input  logic               i_TIMER25K_TIMEOVER_n,
  output logic               o_TIMER25K_CNT,
  output logic               o_TIMER25K_OUTLATCH_LD_n,
  output logic               o_SNAP_ACK_HOST,
  output logic               o_SNAP_ACK_FSM,
  output logic               o_BUSY,
  output logic               o_TIMEOUT,
  output logic               o_FAULT,
  output logic [RETRY_W-1:0] o_RETRY_CNT
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_EXPIRED = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_cnt;
  logic               r_ld_n;
  logic               r_ack_h;
  logic               r_ack_f;
  logic               r_busy;
  logic               r_timeout;
  logic               r_fault;
  logic [RETRY_W-1:0] r_retry;
  logic               r_start_l;
  logic               r_stop_l;
  logic               r_pend_h;
  logic               r_pend_f;
  logic               r_host_lost;
  logic               r_srv_h;
  logic               r_srv_f;

  logic w_pcen;
  logic w_slot13;
  logic w_slot14;
  logic w_slot19;
  logic w_start;
  logic w_stop;
  logic w_retry_left;
  logic w_pick_h;
  logic w_pick_f;
  logic w_unused_slots;

  assign w_pcen         = ~i_CLK2M_PCEN_n;
  assign w_slot13       = ~i_ROT20_n[13];
  assign w_slot14       = ~i_ROT20_n[14];
  assign w_slot19       = ~i_ROT20_n[19];
  assign w_unused_slots = ^{i_ROT20_n[18:15], i_ROT20_n[12:0]};

  // START/STOP seen anywhere in the frame count at the slot-19 commit
  assign w_start      = r_start_l | i_START;
  assign w_stop       = r_stop_l | i_STOP;
  assign w_retry_left = (r_retry < RETRY_W'(MAX_RETRY));

  // FSM over host, unless host lost the last contested arbitration
  assign w_pick_h = r_pend_h & (~r_pend_f | r_host_lost);
  assign w_pick_f = r_pend_f & ~w_pick_h;

  // Timer control FSM with registered outputs
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 1'b0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_fault   <= 1'b0;
      r_retry   <= '0;
      r_start_l <= 1'b0;
      r_stop_l  <= 1'b0;
    end else if (w_pcen) begin
      r_timeout <= 1'b0;
      if (w_slot19) begin
        r_start_l <= 1'b0;
        r_stop_l  <= 1'b0;
      end else begin
        r_start_l <= w_start;
        r_stop_l  <= w_stop;
      end
      case (r_state)
        S_IDLE: begin
          if (w_slot19 && w_start && !w_stop) begin
            r_state <= S_CLEAR;
            r_busy  <= 1'b1;
            r_retry <= '0;
          end
        end
        S_CLEAR: begin
          if (w_slot19) begin
            if (w_stop) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_cnt   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_slot13 && !i_TIMER25K_TIMEOVER_n) begin
            r_state   <= S_EXPIRED;
            r_timeout <= 1'b1;
          end else if (w_slot19 && w_stop) begin
            r_state <= S_IDLE;
            r_cnt   <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        S_EXPIRED: begin
          if (w_slot19) begin
            r_cnt <= 1'b0;
            if (w_stop) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else if (w_retry_left) begin
              r_state <= S_CLEAR;
              r_retry <= r_retry + RETRY_W'(1);
            end else begin
              r_state <= S_FAULT;
              r_busy  <= 1'b0;
              r_fault <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          if (w_slot19 && w_stop) begin
            r_state <= S_IDLE;
            r_fault <= 1'b0;
            r_retry <= '0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Snapshot pending flags, slot-13 latch load and slot-14 acknowledge
  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_pend_h    <= 1'b0;
      r_pend_f    <= 1'b0;
      r_host_lost <= 1'b0;
      r_srv_h     <= 1'b0;
      r_srv_f     <= 1'b0;
      r_ld_n      <= 1'b1;
      r_ack_h     <= 1'b0;
      r_ack_f     <= 1'b0;
    end else if (w_pcen) begin
      r_pend_h <= (r_pend_h & ~(w_slot13 & w_pick_h)) | i_SNAP_REQ_HOST;
      r_pend_f <= (r_pend_f & ~(w_slot13 & w_pick_f)) | i_SNAP_REQ_FSM;
      r_ld_n   <= ~(w_slot13 & (r_pend_h | r_pend_f));
      r_ack_h  <= w_slot14 & r_srv_h;
      r_ack_f  <= w_slot14 & r_srv_f;
      if (w_slot13) begin
        r_srv_h <= w_pick_h;
        r_srv_f <= w_pick_f;
        if (w_pick_f && r_pend_h) begin
          r_host_lost <= 1'b1;
        end else if (w_pick_h) begin
          r_host_lost <= 1'b0;
        end
      end
    end
  end

  assign o_TIMER25K_CNT           = r_cnt;
  assign o_TIMER25K_OUTLATCH_LD_n = r_ld_n;
  assign o_SNAP_ACK_HOST          = r_ack_h;
  assign o_SNAP_ACK_FSM           = r_ack_f;
  assign o_BUSY                   = r_busy;
  assign o_TIMEOUT                = r_timeout;
  assign o_FAULT                  = r_fault;
  assign o_RETRY_CNT              = r_retry;

endmodule
